// File: rtl/eif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eif_pkg
// Description : Shared types and default constants for the EIF neuron scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package eif_pkg;

    localparam int c_DATA_W        = 8;
    localparam int c_THRESH_INIT   = 200;
    localparam int c_THRESH_DEC    = 10;
    localparam int c_THRESH_INC    = 1;
    localparam int c_THRESH_MIN    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } eif_state_t;

endpackage
`default_nettype wire

// File: rtl/eif_update.sv
`default_nettype none
// ============================================================================
// Module      : eif_update
// Description : Combinational single-neuron EIF update (spike, state, threshold).
// Revision    : 1.0 - initial release
// ============================================================================
module eif_update
    import eif_pkg::*;
#(
    parameter int THRESH_DEC = c_THRESH_DEC,
    parameter int THRESH_INC = c_THRESH_INC,
    parameter int THRESH_MIN = c_THRESH_MIN
) (
    input  logic [c_DATA_W-1:0] i_state,
    input  logic [c_DATA_W-1:0] i_threshold,
    input  logic                i_hist,
    input  logic [c_DATA_W-1:0] i_current,
    output logic                o_spike,
    output logic [c_DATA_W-1:0] o_state_nxt,
    output logic [c_DATA_W-1:0] o_threshold_nxt,
    output logic                o_hist_nxt
);

    logic        [8:0] w_sum;
    logic signed [9:0] w_thr_dec;
    logic        [8:0] w_thr_inc;

    assign w_sum     = {1'b0, i_state} + {1'b0, i_current};
    assign w_thr_dec = $signed({2'b00, i_threshold}) - $signed(10'(THRESH_DEC));
    assign w_thr_inc = {1'b0, i_threshold} + 9'(THRESH_INC);

    assign o_spike     = (i_state >= i_threshold);
    assign o_state_nxt = o_spike ? '0 : (w_sum[8] ? 8'hFF : w_sum[7:0]);
    assign o_hist_nxt  = o_spike;

    // Wide intermediates keep both the decrement floor and increment ceiling free of wrap
    always_comb begin
        o_threshold_nxt = i_threshold;
        if (i_hist) begin
            if (w_thr_dec < $signed(10'(THRESH_MIN)))
                o_threshold_nxt = 8'(THRESH_MIN);
            else
                o_threshold_nxt = w_thr_dec[7:0];
        end else begin
            o_threshold_nxt = w_thr_inc[8] ? 8'hFF : w_thr_inc[7:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/eif_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : eif_neuron_scheduler
// Description : Time-multiplexes one EIF datapath across NUM_NEURONS neurons and
//               streams spike events in ascending index order.
// Revision    : 1.0 - initial release
// ============================================================================
module eif_neuron_scheduler
    import eif_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int THRESH_INIT = c_THRESH_INIT,
    parameter int THRESH_DEC  = c_THRESH_DEC,
    parameter int THRESH_INC  = c_THRESH_INC,
    parameter int THRESH_MIN  = c_THRESH_MIN,
    localparam int AW         = $clog2(NUM_NEURONS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cur_we,
    input  logic [AW-1:0]       cur_addr,
    input  logic [c_DATA_W-1:0] cur_data,
    output logic                spike_valid,
    output logic [AW-1:0]       spike_id,
    input  logic                spike_ready,
    output logic                busy,
    output logic                done,
    input  logic [AW-1:0]       mon_addr,
    output logic [c_DATA_W-1:0] mon_state,
    output logic [c_DATA_W-1:0] mon_threshold
);

    localparam logic [AW-1:0]       c_LAST_IDX = AW'(NUM_NEURONS - 1);
    localparam logic [c_DATA_W-1:0] c_THR_INIT = c_DATA_W'(THRESH_INIT);

    eif_state_t          r_fsm;
    eif_state_t          w_fsm_nxt;
    logic [AW-1:0]       r_idx;
    logic [AW-1:0]       w_idx_nxt;
    logic                w_writeback;

    logic [c_DATA_W-1:0] r_state  [NUM_NEURONS];
    logic [c_DATA_W-1:0] r_thresh [NUM_NEURONS];
    logic                r_hist   [NUM_NEURONS];
    logic [c_DATA_W-1:0] r_cur    [NUM_NEURONS];

    logic [c_DATA_W-1:0] r_mon_state;
    logic [c_DATA_W-1:0] r_mon_thresh;

    logic                w_spike;
    logic [c_DATA_W-1:0] w_state_nxt;
    logic [c_DATA_W-1:0] w_thresh_nxt;
    logic                w_hist_nxt;

    eif_update #(
        .THRESH_DEC (THRESH_DEC),
        .THRESH_INC (THRESH_INC),
        .THRESH_MIN (THRESH_MIN)
    ) u_update (
        .i_state         (r_state[r_idx]),
        .i_threshold     (r_thresh[r_idx]),
        .i_hist          (r_hist[r_idx]),
        .i_current       (r_cur[r_idx]),
        .o_spike         (w_spike),
        .o_state_nxt     (w_state_nxt),
        .o_threshold_nxt (w_thresh_nxt),
        .o_hist_nxt      (w_hist_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= ST_IDLE;
            r_idx <= '0;
        end else begin
            r_fsm <= w_fsm_nxt;
            r_idx <= w_idx_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_idx_nxt   = r_idx;
        w_writeback = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                if (start) begin
                    w_fsm_nxt = ST_UPDATE;
                    w_idx_nxt = '0;
                end
            end
            ST_UPDATE: begin
                w_writeback = 1'b1;
                if (w_spike)
                    w_fsm_nxt = ST_EMIT;
                else if (r_idx == c_LAST_IDX)
                    w_fsm_nxt = ST_DONE;
                else
                    w_idx_nxt = r_idx + AW'(1);
            end
            ST_EMIT: begin
                if (spike_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_fsm_nxt = ST_DONE;
                    end else begin
                        w_fsm_nxt = ST_UPDATE;
                        w_idx_nxt = r_idx + AW'(1);
                    end
                end
            end
            ST_DONE: begin
                w_fsm_nxt = ST_IDLE;
            end
            default: begin
                w_fsm_nxt = ST_IDLE;
            end
        endcase
    end

    // Current writes land at the same edge as write-back, so the update sees the old value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_state[i]  <= '0;
                r_thresh[i] <= c_THR_INIT;
                r_hist[i]   <= 1'b0;
                r_cur[i]    <= '0;
            end
            r_mon_state  <= '0;
            r_mon_thresh <= c_THR_INIT;
        end else begin
            if (w_writeback) begin
                r_state[r_idx]  <= w_state_nxt;
                r_thresh[r_idx] <= w_thresh_nxt;
                r_hist[r_idx]   <= w_hist_nxt;
            end
            if (cur_we)
                r_cur[cur_addr] <= cur_data;
            r_mon_state  <= r_state[mon_addr];
            r_mon_thresh <= r_thresh[mon_addr];
        end
    end

    // idx is frozen while in EMIT, so the event id is stable under back-pressure
    assign spike_valid   = (r_fsm == ST_EMIT);
    assign spike_id      = r_idx;
    assign busy          = (r_fsm != ST_IDLE);
    assign done          = (r_fsm == ST_DONE);
    assign mon_state     = r_mon_state;
    assign mon_threshold = r_mon_thresh;

endmodule
`default_nettype wire

// File: doc/eif_neuron_scheduler.md
# eif_neuron_scheduler

Time-multiplexed controller that shares one EIF update datapath among `NUM_NEURONS` virtual neurons. Each neuron's state, adaptive threshold, spike history and input current live in local register arrays. On each `start` pulse (one network timestep) the controller sweeps the neurons in index order and writes back the updated values. Spikes leave as an ordered valid/ready event stream.

## Interface
Parameters:
- `NUM_NEURONS`, 4 — number of virtual neurons; power of two, 2..64.
- `THRESH_INIT`, 200 — threshold value at reset.
- `THRESH_DEC`, 10 — threshold decrement after a spiking timestep.
- `THRESH_INC`, 1 — threshold increment after a non-spiking timestep.
- `THRESH_MIN`, 16 — floor for threshold decrement.

Ports (`AW = $clog2(NUM_NEURONS)`):
- `clk` input 1 — single clock; all logic on rising edge.
- `rst` input 1 — reset is synchronous and active-high.
- `start` input 1 — begin one timestep sweep; honoured only in IDLE, ignored otherwise.
- `cur_we` input 1 — write enable for the current array.
- `cur_addr` input AW — neuron index for the current write.
- `cur_data` input 8 — input current value.
- `spike_valid` output 1 — spike event available.
- `spike_id` output AW — index of the spiking neuron.
- `spike_ready` input 1 — consumer accepts the event.
- `busy` output 1 — sweep in progress (not IDLE).
- `done` output 1 — one-cycle pulse when a sweep completes.
- `mon_addr` input AW — monitor select.
- `mon_state` output 8 — registered state of neuron `mon_addr`.
- `mon_threshold` output 8 — registered threshold of neuron `mon_addr`.

## Operation
- FSM states:
  - IDLE: `start` → UPDATE with index 0.
  - UPDATE: process neuron `idx`. Spike → EMIT. No spike and `idx == N-1` → DONE. No spike otherwise → UPDATE with `idx+1`.
  - EMIT: hold until `spike_valid && spike_ready`. Then `idx == N-1` → DONE, else → UPDATE with `idx+1`.
  - DONE: assert `done`, then → IDLE.
- Per-neuron update, computed from stored values in the UPDATE cycle and written back at the end of that cycle:
  - `spike = state >= threshold` (unsigned 8-bit compare).
  - `state' = spike ? 0 : min(state + current, 255)` (9-bit sum, saturating).
  - `threshold' = hist ? max(threshold - THRESH_DEC, THRESH_MIN) : min(threshold + THRESH_INC, 255)`; computed with signed/9-bit intermediates, no wrap.
  - `hist' = spike`. History therefore always refers to the previous timestep of the same neuron.
- Current array:
  - Writes commit on any cycle, including while busy.
  - A write to the neuron being updated in the same cycle is not seen by that update; the update reads the old value.
  - Currents persist across sweeps until rewritten.
- `spike_id` and `spike_valid` are stable while stalled. Events leave in ascending index order, one per spiking neuron per sweep.
- Monitor: `mon_state` and `mon_threshold` show the array contents selected by `mon_addr`, with one-cycle latency and post-write-back values.

## Timing
- Reset values:
  - Outputs: `spike_valid=0`, `spike_id=0`, `busy=0`, `done=0`, `mon_state=0`, `mon_threshold=THRESH_INIT` (when `mon_addr` is held).
  - Arrays: every state 0, threshold `THRESH_INIT`, hist 0, current 0; FSM in IDLE, `idx=0`.
- `start` is sampled in cycle t (IDLE). Neuron i is updated in cycle t+1+i when no spikes occur. `done` is high in cycle t+N+1. `busy` is high cycles t+1..t+N+1.
- A spiking neuron adds at least one cycle: `spike_valid` rises in the cycle after its UPDATE cycle. With `spike_ready` held high, the next UPDATE follows immediately after the accept cycle.
- `start` during DONE or busy is dropped; no queuing.
- `rst` mid-sweep aborts immediately. A pending spike event is discarded. Neurons not yet processed keep no partial updates, because everything returns to reset values.

## Structure
- Package `eif_pkg`:
  - FSM state enum (IDLE, UPDATE, EMIT, DONE).
  - 8-bit data width constant.
  - Default threshold constants.
- Sub-module `eif_update`, purely combinational. Inputs: state, threshold, hist, current. Outputs: spike, next state, next threshold, next hist. The scheduler instantiates it once, muxed by `idx`.

## Test plan
- N=4, all currents 0, one `start` → no events; `done` at t+5; thresholds all 201.
- Neuron 2 current=250, other currents 0, two sweeps → sweep 1: no spike, state 250. Sweep 2: 250≥201 → event `spike_id=2`, state 0, threshold 202.
- Sweep 3 following the previous case → threshold 192 (history set); state 250 after sweep 3.
- Neurons 0 and 3 spike, `spike_ready` low for 5 cycles → `spike_id=0` held stable for 5 cycles; ids arrive in order 0 then 3; `done` delayed accordingly.
- `cur_we` to neuron 1 in neuron 1's UPDATE cycle, data 50, old value 10 → state adds 10 this sweep and 50 next sweep.
- `rst` asserted in EMIT → `spike_valid` drops the next cycle; monitor reads state 0 and threshold 200 for every neuron; a later `start` works normally.
